// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
// ready_o drops in the accepting cycle and stays low until the one-cycle DONE state.
module div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic                  annul_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   dvd;
  logic [DATA_W-1:0]   dvsr;
  logic                q_neg;
  logic                r_neg;

  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     part;
  logic                fits;
  logic [DATA_W-1:0]   rem_nxt, quo_nxt;
  logic                cancel;

  always_comb begin
    a_neg = signed_i & opdata1_i[DATA_W-1];
    b_neg = signed_i & opdata2_i[DATA_W-1];
    a_mag = a_neg ? -opdata1_i : opdata1_i;
    b_mag = b_neg ? -opdata2_i : opdata2_i;
  end

  // Dividend bits shift out of dvd into the partial remainder while quotient
  // bits shift in from the bottom, so dvd ends up holding the quotient.
  always_comb begin
    part    = {rem, dvd[DATA_W-1]};
    fits    = part >= {1'b0, dvsr};
    rem_nxt = fits ? DATA_W'(part - {1'b0, dvsr}) : part[DATA_W-1:0];
    quo_nxt = {dvd[DATA_W-2:0], fits};
  end

  // A stalled pipeline keeps start_i high, so losing it mid-operation means cancel.
  assign cancel = annul_i | ~start_i;

  always_comb begin
    ready_o = 1'b1;
    unique case (state)
      IDLE:        ready_o = ~(start_i & ~annul_i);
      ON, DIVZERO: ready_o = cancel;
      DONE:        ready_o = 1'b1;
      default:     ready_o = 1'b1;
    endcase
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result_o <= '0;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dvsr     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DIVZERO;
            end else begin
              state <= ON;
              dvd   <= a_mag;
              dvsr  <= b_mag;
              rem   <= '0;
              cnt   <= '0;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
            end
          end
        end
        DIVZERO: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            result_o <= '0;
            state    <= DONE;
          end
        end
        ON: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            rem <= rem_nxt;
            dvd <= quo_nxt;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state    <= DONE;
              result_o <= {(r_neg ? -rem_nxt : rem_nxt), (q_neg ? -quo_nxt : quo_nxt)};
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, hand-written abort/reset/
// back-to-back sequences, and random divides against an arithmetic reference.
module tb_div_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, start_i, signed_i, annul_i;
  logic [W-1:0]  opdata1_i, opdata2_i;
  logic [2*W-1:0] result_o;
  logic          ready_o, busy_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cycle_no = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle_no <= cycle_no + 1;

  div_unit #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .annul_i   (annul_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'h0, a};
      sb = {32'h0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; that cycle is cycle 0. Returns at the falling
  // edge of the first ready cycle with start_i still high.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat);
    logic [63:0] prev;
    bit held, done;
    start_i   = 1'b1;
    annul_i   = 1'b0;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    prev = result_o;
    held = 1'b1;
    done = 1'b0;
    lat  = 0;
    while (!done) begin
      @(negedge clk);
      if (ready_o) begin
        done = 1'b1;
      end else begin
        if (result_o !== prev) held = 1'b0;
        if (lat >= 100) begin
          done = 1'b1;
        end else begin
          @(posedge clk);
          #1;
          lat++;
          opdata1_i = $urandom;
          opdata2_i = $urandom;
          signed_i  = ($urandom & 1) != 0;
        end
      end
    end
    res = result_o;
    check("result_held_while_busy", {63'b0, held}, 64'd1);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] res, exp_res;
  int          lat;
  int unsigned t1, t2;
  logic [31:0] ra, rb;
  bit          rs;

  initial begin
    vecs[0] = '{1'b0, 32'd100,       32'd7,          {32'h2,        32'hE},        33};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,  32'h2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
    vecs[2] = '{1'b1, 32'h7,         32'hFFFFFFFE,   {32'h1,        32'hFFFFFFFD}, 33};
    vecs[3] = '{1'b0, 32'h1234,      32'h0,          64'h0,                        2};
    vecs[4] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,   {32'h0,        32'h80000000}, 33};
    vecs[5] = '{1'b0, 32'hFFFFFFFF,  32'h1,          {32'h0,        32'hFFFFFFFF}, 33};
    vecs[6] = '{1'b1, 32'h5,         32'h0,          64'h0,                        2};
    vecs[7] = '{1'b0, 32'h3,         32'hFFFFFFFF,   {32'h3,        32'h0},        33};

    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result", result_o, 64'h0);
    check("reset_busy",   {63'b0, busy_o},  64'd0);
    check("reset_ready",  {63'b0, ready_o}, 64'd1);
    step();
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      step();
      start_i = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_idle_after", i), {62'b0, busy_o, ready_o}, 64'd1);
      step();
    end

    // Annul mid-divide keeps the old result; a restart takes the full latency.
    run_div(1'b0, 32'd100, 32'd7, res, lat);
    step();
    start_i = 1'b0;
    step();
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    repeat (10) step();
    annul_i = 1'b1;
    @(negedge clk);
    check("annul_ready", {63'b0, ready_o}, 64'd1);
    step();
    annul_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    check("annul_busy",   {63'b0, busy_o}, 64'd0);
    check("annul_result", result_o, {32'h2, 32'hE});
    step();
    run_div(1'b0, 32'd1000, 32'd3, res, lat);
    check("restart_result",  res, {32'd1, 32'd333});
    check("restart_latency", 64'(lat), 64'd33);
    step();
    start_i = 1'b0;
    step();

    // Annul together with start in IDLE is never accepted.
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
    @(negedge clk);
    check("idle_annul_ready", {63'b0, ready_o}, 64'd1);
    step();
    start_i = 1'b0; annul_i = 1'b0;
    @(negedge clk);
    check("idle_annul_busy", {63'b0, busy_o}, 64'd0);
    step();

    // Dropping start_i mid-divide aborts without touching the result.
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5;
    repeat (5) step();
    start_i = 1'b0;
    step();
    @(negedge clk);
    check("drop_busy",   {63'b0, busy_o}, 64'd0);
    check("drop_result", result_o, {32'd1, 32'd333});
    step();

    // Reset mid-divide.
    start_i = 1'b1; opdata1_i = 32'd77; opdata2_i = 32'd5;
    repeat (5) step();
    rst = 1'b1;
    start_i = 1'b0;
    step();
    @(negedge clk);
    check("midrst_busy",   {63'b0, busy_o}, 64'd0);
    check("midrst_result", result_o, 64'h0);
    step();
    rst = 1'b0;
    step();

    // Back-to-back with start held across the DONE boundary.
    run_div(1'b0, 32'd100, 32'd7, res, lat);
    t1 = cycle_no;
    check("b2b_first", res, {32'h2, 32'hE});
    step();
    run_div(1'b0, 32'd50, 32'd5, res, lat);
    t2 = cycle_no;
    check("b2b_second",  res, {32'h0, 32'hA});
    check("b2b_latency", 64'(lat), 64'd33);
    check("b2b_spacing", 64'(t2 - t1), 64'd34);
    step();
    start_i = 1'b0;
    step();

    // Random divides against the arithmetic reference.
    for (int k = 0; k < 40; k++) begin
      rs = ($urandom & 1) != 0;
      ra = $urandom;
      case ($urandom_range(3))
        0: rb = 32'h0;
        1: rb = $urandom_range(20, 1);
        2: rb = (($urandom & 1) != 0) ? 32'hFFFFFFFF : 32'h1;
        default: rb = $urandom;
      endcase
      if (($urandom & 3) == 0) ra = 32'h80000000;
      exp_res = ref_div(rs, ra, rb);
      run_div(rs, ra, rb, res, lat);
      check($sformatf("rand%0d_result", k), res, exp_res);
      check($sformatf("rand%0d_latency", k), 64'(lat), (rb == 32'h0) ? 64'd2 : 64'd33);
      step();
      if (($urandom & 1) != 0) begin
        start_i = 1'b0;
        repeat ($urandom_range(2)) step();
      end
    end
    start_i = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider in the execute stage; serves DIV/DIVU.
- Produces {HI=remainder, LO=quotient} for the HI/LO write path.
- Drives the execute-stage ready signal (alu_ready_E) consumed by the hazard unit. While ready_o is low, the hazard unit freezes F/D/E/M/W and suppresses flushes.

Parameters:
- DATA_W, 32, operand width; iteration count equals DATA_W.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  divide instruction present in E; held high by the stalled pipeline until completion
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- annul_i  in  1  abort the current operation (E-stage flush or instruction cancelled)
- opdata1_i  in  DATA_W  dividend; sampled only on the accepting cycle
- opdata2_i  in  DATA_W  divisor; sampled only on the accepting cycle
- result_o  out  2*DATA_W  {remainder[DATA_W-1:0], quotient[DATA_W-1:0]}; registered
- ready_o  out  1  combinational; 0 requests a pipeline stall
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, result_o=0, internal counter/shift regs=0, busy_o=0, ready_o=1 (unless start_i=1 in the same cycle).
- States: IDLE, DIVZERO, ON, DONE.
- IDLE:
  - start_i=1 & annul_i=0 & divisor!=0: latch operands, go to ON.
  - start_i=1 & annul_i=0 & divisor==0: go to DIVZERO.
  - otherwise stay in IDLE.
  - ready_o = ~(start_i & ~annul_i), so the stall begins in the accepting cycle itself.
- Signed preprocessing (at acceptance, when signed_i=1):
  - Take magnitudes of both operands.
  - Record q_neg = sign(dividend) XOR sign(divisor).
  - Record r_neg = sign(dividend).
- ON:
  - Exactly DATA_W cycles, one quotient bit per cycle, MSB first.
  - Partial remainder is DATA_W+1 bits; trial subtract; bit=1 if the result is non-negative.
  - Counter runs 0..DATA_W-1; go to DONE after the last iteration.
  - ready_o=0.
- DIVZERO: one cycle, ready_o=0; load result_o=0; go to DONE.
- DONE:
  - ready_o=1 for exactly one cycle; result_o is already valid this cycle.
  - Go to IDLE unconditionally.
  - Apply sign fix-up to result_o on the ON→DONE transition: negate the quotient if q_neg, negate the remainder if r_neg.
- Latency from the accepting cycle (cycle 0):
  - Normal divide: ready_o high in cycle DATA_W+1 (33 for DATA_W=32), i.e. 33 stall cycles.
  - Divide by zero: ready_o high in cycle 2.
- Back-to-back divides: after DONE the pipeline advances; a new divide in E sees IDLE with start_i=1 next cycle and is accepted. No bubble is required and there is no double-accept of the old instruction.
- annul_i=1 in any state: next state IDLE; result_o unchanged; ready_o=1 in that cycle.
- start_i falling while in ON or DIVZERO: treated as annul (abort to IDLE).
- result_o:
  - Holds its value until the next completed operation.
  - Never changes during ON (iteration state is held in separate registers).
  - Aborted operations never update it.
- Operand changes on opdata*_i after acceptance are ignored.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (natural wrap of the negate). No trap.
- rst mid-operation: abort immediately to the reset values above.

Test Plan:
- DIVU 100/7, start_i held: ready_o=0 for cycles 0..32, ready_o=1 in cycle 33 only; result_o = {0x00000002, 0x0000000E}.
- DIV -7/2 (0xFFFFFFF9/0x00000002): result_o = {0xFFFFFFFF, 0xFFFFFFFD}. DIV 7/-2 gives {0x00000001, 0xFFFFFFFD}.
- Divide by zero, 0x1234/0: ready_o low in cycles 0–1, high in cycle 2; result_o = 0.
- Signed overflow 0x80000000/0xFFFFFFFF: result_o = {0x00000000, 0x80000000} after 33 stall cycles. DIVU 0xFFFFFFFF/1 gives {0, 0xFFFFFFFF}.
- Abort mid-divide: assert annul_i at cycle 10 → busy_o=0 next cycle, ready_o=1, result_o keeps its prior value. A following start_i restarts with full 33-cycle latency.
- Back-to-back: 100/7 then 50/5 with start_i high across the DONE boundary → second result {0, 0x0000000A} lands 34 cycles after the first DONE. rst asserted at cycle 5 → state IDLE, result_o=0.
